// File: rtl/result_uart_tx_if.sv
// Bundle of the result-capture and UART status signals between the core side and result_uart_tx.
// The master drives result_in; the slave (the transmitter) drives the line and status outputs.
interface result_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [15:0]                   result_in;
  logic                          tx;
  logic                          busy;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output result_in,
    input  tx,
    input  busy,
    input  overflow,
    input  fifo_count
  );

  modport slave (
    input  result_in,
    output tx,
    output busy,
    output overflow,
    output fifo_count
  );
endinterface

// File: rtl/result_uart_tx.sv
// Captures every change of the 16-bit result bus into a small FIFO and sends each word
// as two 8N1 UART frames, low byte first.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  result_uart_tx_if.slave   port_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg;
  logic [15:0]     last_q;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_reg;
  logic            overflow_reg;
  logic [7:0]      shreg;
  logic [7:0]      word_hi;
  logic            byte_sel;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   baud_cnt;
  logic            tx_reg;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic baud_done;

  always_comb begin
    push_req  = (port_if.result_in != last_q);
    pop       = (state_reg == IDLE) && (count_reg != '0);
    full      = (count_reg == CW'(FIFO_DEPTH));
    // A full FIFO still takes a push when the transmitter frees a slot on the same edge
    push_ok   = push_req && (!full || pop);
    baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem[wr_ptr] <= port_if.result_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_req)
        last_q <= port_if.result_in;
      if (push_req && !push_ok)
        overflow_reg <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      tx_reg    <= 1'b1;
      shreg     <= '0;
      word_hi   <= '0;
      byte_sel  <= 1'b0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shreg     <= mem[rd_ptr][7:0];
            word_hi   <= mem[rd_ptr][15:8];
            byte_sel  <= 1'b0;
            baud_cnt  <= '0;
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_reg    <= shreg[0];
            state_reg <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              // shreg shifts right so the next bit to send is always at [1]
              bit_cnt <= bit_cnt + 1'b1;
              tx_reg  <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!byte_sel) begin
              shreg     <= word_hi;
              byte_sel  <= 1'b1;
              tx_reg    <= 1'b0;
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign port_if.tx         = tx_reg;
  assign port_if.busy       = (state_reg != IDLE) || (count_reg != '0);
  assign port_if.overflow   = overflow_reg;
  assign port_if.fifo_count = count_reg;
endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: stimulus pushes expected words into a queue, an independent
// UART receiver decodes the tx line and pops/compares each completed word.
module tb_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   rx_words = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur;
  bit   ovf_exp;

  result_uart_tx_if #(.FIFO_DEPTH(DEPTH)) u_if ();

  result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .port_if(u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      if (u_if.busy === 1'b0) done = 1;
      else tick();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", u_if.busy, bound);
    end
  endtask

  task automatic drive(input logic [15:0] v, input bit expect_sent);
    u_if.result_in = v;
    cur = v;
    if (expect_sent) exp_q.push_back(v);
    $display("drive result_in=%04h sent=%0b", v, expect_sent);
  endtask

  // Receiver: called with the first start-bit cycle already sampled.
  task automatic recv_byte(output logic [7:0] b, output int errs, output bit ab);
    ab = 0; errs = 0; b = '0;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(s == 0 && c == 0)) @(negedge clk);
        if (reset !== 1'b0) begin
          ab = 1;
          return;
        end
        if (s == 0) begin
          if (u_if.tx !== 1'b0) errs++;
        end else if (s == 9) begin
          if (u_if.tx !== 1'b1) errs++;
        end else if (c == 0) begin
          b[s-1] = u_if.tx;
        end else if (u_if.tx !== b[s-1]) begin
          errs++;
        end
      end
    end
  endtask

  initial begin : monitor
    logic [7:0] lo, hi;
    int e1, e2, e3;
    bit ab;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && u_if.tx === 1'b0) begin
        recv_byte(lo, e1, ab);
        if (ab) continue;
        @(negedge clk);
        if (reset !== 1'b0) continue;
        e3 = (u_if.tx !== 1'b0) ? 1 : 0;  // high byte must start with no gap
        recv_byte(hi, e2, ab);
        if (ab) continue;
        @(negedge clk);
        if (reset === 1'b0 && u_if.tx !== 1'b1) e3++;
        rx_words++;
        check("framing", e1 + e2 + e3, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected word: got %04h expected none", {hi, lo});
        end else begin
          logic [15:0] w;
          w = exp_q.pop_front();
          $display("rx word %04h expected %04h", {hi, lo}, w);
          check("word", {hi, lo}, w);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] v;
    int rx0;
    reset = 1'b1;
    u_if.result_in = '0;
    cur = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("reset_idle", {u_if.tx, u_if.busy, u_if.overflow, 29'(u_if.fifo_count)},
            {1'b1, 1'b0, 1'b0, 29'd0});
      tick();
    end

    // Single word timing
    drive(16'h12A5, 1);
    tick();
    check("cap_count", u_if.fifo_count, 1);
    check("cap_tx", u_if.tx, 1);
    tick();
    check("pop_tx", u_if.tx, 0);
    check("pop_count", u_if.fifo_count, 0);
    repeat (79) tick();
    check("busy_last", u_if.busy, 1);
    tick();
    check("busy_drop", u_if.busy, 0);
    tick();

    // No-change filter
    rx0 = rx_words;
    drive(16'h0042, 1);
    repeat (201) tick();
    u_if.result_in = 16'h0042;
    wait_idle(300);
    tick(); tick();
    check("one_word", rx_words - rx0, 1);

    // Overflow from idle
    for (int i = 1; i <= 6; i++) begin
      drive(16'(i), i <= DEPTH + 1);
      tick();
      if (i == 5) check("no_ovf_yet", u_if.overflow, 0);
    end
    check("ovf_count", u_if.fifo_count, DEPTH);
    check("ovf_flag", u_if.overflow, 1);
    wait_idle(1000);
    check("ovf_sticky", u_if.overflow, 1);
    tick(); tick();
    check("ovf_drained", exp_q.size(), 0);

    // Full FIFO plus pop on the same edge
    reset = 1'b1;
    u_if.result_in = '0;
    cur = '0;
    tick(); tick();
    reset = 1'b0;
    check("ovf_cleared", u_if.overflow, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(16'(i * 16'h1111), 1);
      tick();
    end
    check("full", u_if.fifo_count, DEPTH);
    repeat (77) tick();
    check("still_full", u_if.fifo_count, DEPTH);
    drive(16'h6666, 1);
    tick();
    check("full_pop_count", u_if.fifo_count, DEPTH);
    check("full_pop_ovf", u_if.overflow, 0);

    // Reset mid-frame (high byte data of the word in flight)
    repeat (52) tick();
    reset = 1'b1;
    u_if.result_in = '0;
    cur = '0;
    exp_q.delete();
    tick();
    check("rst_tx", u_if.tx, 1);
    check("rst_count", u_if.fifo_count, 0);
    check("rst_busy", u_if.busy, 0);
    reset = 1'b0;
    tick();
    drive(16'h00FF, 1);
    tick();
    wait_idle(300);
    tick(); tick();

    // Randomized bursts from idle
    ovf_exp = 0;
    for (int r = 0; r < 15; r++) begin
      wait_idle(1000);
      tick(); tick();
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) begin
        v = 16'($urandom);
        if (v == cur) v = v ^ 16'h0001;
        drive(v, i <= DEPTH);
        tick();
      end
      if (n > DEPTH + 1) ovf_exp = 1;
      check("burst_count", u_if.fifo_count, (n == 1) ? 1 : ((n - 1 > DEPTH) ? DEPTH : n - 1));
      check("burst_ovf", u_if.overflow, ovf_exp);
    end
    wait_idle(1000);
    repeat (5) tick();
    check("all_delivered", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serial output port for the RISC-V core's 16-bit `result` bus. It watches `result` every cycle and captures each new value into a small FIFO. Each captured word is sent as two 8N1 UART frames, low byte first, so a board or bench can log the core's results over a single pin. It sits beside `RISCVProcessor` at top level and is driven directly by that module's `result` output.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4, number of 16-bit FIFO entries; must be a power of two, at least 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `result_in`  in  16  the processor's `result` bus.
- `tx`  out  1  UART line, registered; idles high.
- `busy`  out  1  high when the FIFO is non-empty or the transmitter is not in IDLE.
- `overflow`  out  1  sticky flag; set when a change is dropped because the FIFO is full; cleared only by `reset`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

## Operation
- Change detect:
  - `last_q` (16 bits) holds the last sampled value; reset value is 0.
  - On any edge where `result_in != last_q`:
    - `last_q <= result_in`;
    - a push of `result_in` is requested.
  - Equal values are ignored.
  - Consequence: a value of 0 is never sent straight after reset.
- FIFO:
  - Circular buffer with `wr_ptr`/`rd_ptr`, both of which wrap at `FIFO_DEPTH`.
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the push is dropped and `overflow <= 1`.
  - `last_q` is updated even when the push is dropped.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Transmitter FSM states: IDLE, START, DATA, STOP. Registers:
  - `shreg` (8 bits)
  - `word_hi` (8 bits)
  - `byte_sel` (1 bit)
  - `bit_cnt` (3 bits)
  - `baud_cnt` (counts 0..`CLKS_PER_BIT`-1)
- IDLE:
  - `tx`=1.
  - If FIFO is non-empty: pop, `shreg <= word[7:0]`, `word_hi <= word[15:8]`, `byte_sel <= 0`, `baud_cnt <= 0`, go to START with `tx <= 0`.
- START:
  - `tx`=0 for `CLKS_PER_BIT` cycles.
  - Then go to DATA with `bit_cnt`=0 and `tx <= shreg[0]`.
- DATA:
  - Each bit is held `CLKS_PER_BIT` cycles; bits are sent LSB first.
  - After bit 7, go to STOP with `tx <= 1`.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - If `byte_sel`==0: `shreg <= word_hi`, `byte_sel <= 1`, go directly to START with `tx <= 0`.
  - Else go to IDLE.
- `baud_cnt` resets to 0 on every state or bit change.
- `busy` = (state != IDLE) | (count != 0), decoded combinationally from registers.

## Timing
- Reset values (one cycle after `reset` is sampled high): `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, state IDLE, `last_q`=0, pointers 0.
- Reset mid-frame: the frame is abandoned, `tx` is 1 on the next cycle, and FIFO contents are discarded.
- Capture latency: a change sampled at edge k gives `fifo_count` incremented after edge k.
- If the FSM is IDLE, the word is popped at edge k+1 and `tx` falls after edge k+1.
- Word duration:
  - START to final stop bit is 20×`CLKS_PER_BIT` cycles.
  - No idle gap between the two bytes of a word.
  - At least one IDLE cycle (`tx`=1) between consecutive words.
- Stop bit is 1 bit time; no parity.
- `overflow` rises on the edge after the rejected push and stays high until reset.

## Test plan
- Reset check: assert `reset` for 2 cycles with `result_in`=0, hold 50 cycles → `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0 throughout.
- Single word (`CLKS_PER_BIT`=4): change `result_in` 0→0x12A5 → `tx` falls 1 cycle after capture, then:
  - frame bits 0,1,0,1,0,0,1,0,1,1 (0xA5), immediately followed by 0,0,1,0,0,1,0,0,0,1 (0x12);
  - each bit lasts exactly 4 cycles, 80 cycles total;
  - `busy` drops 1 cycle after the final stop bit.
- No-change filter: hold `result_in`=0x0042 for 200 cycles after its first capture, then set it to 0x0042 again → exactly one word transmitted.
- Overflow (`FIFO_DEPTH`=4): present 0x0001..0x0006 on 6 consecutive edges starting from IDLE:
  - 0x0001 is popped immediately;
  - 0x0002..0x0005 fill the FIFO;
  - 0x0006 is dropped, so `overflow`=1 and `fifo_count`=4;
  - the UART carries 0x0001..0x0005 in order, then `busy`=0 with `overflow` still 1.
- Full + pop same edge: with the FIFO full, a change coincides with the FSM's IDLE pop → push accepted, `fifo_count` stays 4, `overflow` stays 0.
- Reset mid-frame: assert `reset` during DATA of the high byte → `tx`=1 the next cycle, `fifo_count`=0; a later change to 0x00FF transmits normally.
